// File: rtl/eva_mem_pkg.sv
// Shared constants and helpers for the EVA multi-port behavioural memory.
package eva_mem_pkg;

  localparam int unsigned EVA_ADDR_W = 32;
  localparam int unsigned EVA_PORT_W = 3;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b,
                                            input logic msk);
    return msk ? new_b : old_b;
  endfunction

endpackage

// File: rtl/eva_mem_mp_if.sv
// Request/response bundle between requesters (master) and the memory (slave).
interface eva_mem_mp_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NPORT = 2
);
  import eva_mem_pkg::*;

  logic [NPORT-1:0]              req_valid;
  logic [NPORT-1:0]              req_ready;
  logic [NPORT-1:0]              req_we;
  logic [NPORT*EVA_ADDR_W-1:0]   req_addr;
  logic [NPORT*(WIDTH/8)-1:0]    req_wmsk;
  logic [NPORT*WIDTH-1:0]        req_wdata;
  logic [NPORT-1:0]              rsp_valid;
  logic [WIDTH-1:0]              rsp_rdata;
  logic                          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wmsk, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmsk, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/eva_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, one per cycle.
module eva_rr_arb
  import eva_mem_pkg::*;
#(
  parameter int unsigned NPORT = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NPORT-1:0]      i_req,
  output logic [NPORT-1:0]      o_gnt,
  output logic [EVA_PORT_W-1:0] o_gnt_idx
);

  logic [EVA_PORT_W-1:0] r_ptr;
  logic                  w_any;
  logic [31:0]           w_pos;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_any     = 1'b0;
    w_pos     = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      w_pos = 32'(r_ptr) + k;
      if (w_pos >= NPORT) w_pos = w_pos - NPORT;
      for (int unsigned i = 0; i < NPORT; i++) begin
        // Grants are suppressed during reset so nothing is accepted then.
        if (RST_N && !w_any && (w_pos == i) && i_req[i]) begin
          w_any     = 1'b1;
          o_gnt[i]  = 1'b1;
          o_gnt_idx = EVA_PORT_W'(i);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (o_gnt_idx == EVA_PORT_W'(NPORT - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/eva_mem_mp.sv
// Multi-port behavioural memory: round-robin request arbitration, byte-masked writes,
// fixed-latency in-order responses with out-of-range error flag.
module eva_mem_mp
  import eva_mem_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 128,
  parameter int unsigned      NPORT    = 2,
  parameter int unsigned      RD_LAT   = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic        CLK,
  input logic        RST_N,
  eva_mem_mp_if.slave bus
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  vld;
    logic [EVA_PORT_W-1:0] port;
    logic                  err;
    logic [WIDTH-1:0]      data;
  } rsp_t;

  // Loaded once at time zero; reset deliberately leaves contents alone.
  logic [WIDTH-1:0] r_mem [DEPTH] = '{default: INIT_VAL};

  logic [NPORT-1:0]      w_gnt;
  logic [EVA_PORT_W-1:0] w_gnt_idx;
  logic                  w_any;
  logic                  w_we;
  logic [EVA_ADDR_W-1:0] w_addr;
  logic [NB-1:0]         w_wmsk;
  logic [WIDTH-1:0]      w_wdata;
  logic                  w_oor;
  logic [AW-1:0]         w_idx;
  logic [WIDTH-1:0]      w_old;
  logic [WIDTH-1:0]      w_merged;
  rsp_t                  w_stage;
  rsp_t                  r_pipe [RD_LAT];

  eva_rr_arb #(
    .NPORT (NPORT)
  ) u_arb (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_req     (bus.req_valid),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign bus.req_ready = w_gnt;
  assign w_any         = |w_gnt;

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wmsk  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (w_gnt[i]) begin
        w_we    = bus.req_we[i];
        w_addr  = bus.req_addr[i*EVA_ADDR_W +: EVA_ADDR_W];
        w_wmsk  = bus.req_wmsk[i*NB +: NB];
        w_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_oor = w_addr >= EVA_ADDR_W'(DEPTH);
  assign w_idx = w_addr[AW-1:0];
  assign w_old = r_mem[w_idx];

  always_comb begin
    w_merged = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      w_merged[b*8 +: 8] = byte_merge(w_old[b*8 +: 8], w_wdata[b*8 +: 8], w_wmsk[b]);
    end
  end

  always_comb begin
    w_stage      = '0;
    w_stage.vld  = w_any;
    w_stage.port = w_gnt_idx;
    w_stage.err  = w_any && w_oor;
    w_stage.data = (w_any && !w_we && !w_oor) ? w_old : '0;
  end

  always_ff @(posedge CLK) begin
    if (w_any && w_we && !w_oor) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_stage;
      for (int unsigned i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Invalid stages carry zero data/err, so the outputs read 0 when idle.
  always_comb begin
    bus.rsp_valid = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      bus.rsp_valid[i] = r_pipe[RD_LAT-1].vld && (r_pipe[RD_LAT-1].port == EVA_PORT_W'(i));
    end
    bus.rsp_rdata = r_pipe[RD_LAT-1].data;
    bus.rsp_err   = r_pipe[RD_LAT-1].err;
  end

endmodule

// File: tb/tb_eva_mem_mp.sv
// Bench for eva_mem_mp: table vectors and corner sequences on a 2-port RD_LAT=1 instance,
// randomized traffic against a reference model on a 3-port RD_LAT=3 instance.
module tb_eva_mem_mp;
  import eva_mem_pkg::*;

  localparam int unsigned W      = 32;
  localparam int unsigned NPA    = 2;
  localparam int unsigned DEPA   = 128;
  localparam logic [31:0] INITA  = 32'hA5A5A5A5;
  localparam int unsigned NPB    = 3;
  localparam int unsigned LATB   = 3;
  localparam int unsigned DEPB   = 20;
  localparam int unsigned N_RAND = 400;
  localparam int unsigned N_EXP  = N_RAND + 64;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  eva_mem_mp_if #(.WIDTH(W), .NPORT(NPA)) bus_a ();
  eva_mem_mp_if #(.WIDTH(W), .NPORT(NPB)) bus_b ();

  eva_mem_mp #(
    .WIDTH (W), .DEPTH (DEPA), .NPORT (NPA), .RD_LAT (1), .INIT_VAL (INITA)
  ) u_dut_a (
    .CLK   (clk),
    .RST_N (rst_a),
    .bus   (bus_a)
  );

  eva_mem_mp #(
    .WIDTH (W), .DEPTH (DEPB), .NPORT (NPB), .RD_LAT (LATB), .INIT_VAL (32'h0)
  ) u_dut_b (
    .CLK   (clk),
    .RST_N (rst_b),
    .bus   (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wmsk;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } vec_t;

  vec_t vt [15];

  task automatic a_txn(input vec_t v);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bus_a.req_valid                 = '0;
    bus_a.req_valid[v.port]         = 1'b1;
    bus_a.req_we[v.port]            = v.we;
    bus_a.req_addr[v.port*32 +: 32] = v.addr;
    bus_a.req_wmsk[v.port*4 +: 4]   = v.wmsk;
    bus_a.req_wdata[v.port*32 +: 32] = v.wdata;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (bus_a.req_ready[v.port]) begin
        got = 1'b1;
        @(posedge clk);
        #1 bus_a.req_valid = '0;
      end else begin
        @(negedge clk);
      end
    end
    bus_a.req_valid = '0;
    chk({v.name, " accepted"}, 64'(got), 64'd1);
    if (got) begin
      @(negedge clk);
      chk({v.name, " rsp_valid"}, 64'(bus_a.rsp_valid), 64'(2'b01 << v.port));
      chk({v.name, " rdata"}, 64'(bus_a.rsp_rdata), 64'(v.rdata));
      chk({v.name, " err"}, 64'(bus_a.rsp_err), 64'(v.err));
    end
  endtask

  // Reference model for instance B.
  logic [31:0]    mmem [DEPB];
  int             mptr;
  bit             pend [NPB];
  logic           p_we [NPB];
  logic [31:0]    p_addr [NPB];
  logic [3:0]     p_msk [NPB];
  logic [31:0]    p_wd [NPB];
  logic [NPB-1:0] exp_v [N_EXP];
  logic [31:0]    exp_d [N_EXP];
  logic           exp_e [N_EXP];

  task automatic b_three(input bit do_rst);
    @(negedge clk);
    bus_b.req_valid = '0;
    bus_b.req_we    = '0;
    for (int k = 0; k < 3; k++) begin
      bus_b.req_addr[31:0] = 32'(k + 1);
      bus_b.req_valid[0]   = 1'b1;
      #1 chk("b3 ready", 64'(bus_b.req_ready[0]), 64'd1);
      @(posedge clk);
      #1;
      if (k == 2) begin
        bus_b.req_valid = '0;
        if (do_rst) rst_b = 1'b0;
      end
      @(negedge clk);
      chk("b3 latency valid", 64'(bus_b.rsp_valid), (k == 2) ? 64'd1 : 64'd0);
      if (k == 2) chk("b3 rdata a1", 64'(bus_b.rsp_rdata), 64'(mmem[1]));
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!do_rst && k < 2) begin
        chk("b3 tail valid", 64'(bus_b.rsp_valid), 64'd1);
        chk("b3 tail rdata", 64'(bus_b.rsp_rdata), 64'(mmem[k+2]));
      end else begin
        chk("b3 quiet valid", 64'(bus_b.rsp_valid), 64'd0);
        chk("b3 quiet rdata", 64'(bus_b.rsp_rdata), 64'd0);
        chk("b3 quiet err", 64'(bus_b.rsp_err), 64'd0);
      end
      if (k == 2) rst_b = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_g [4];
    logic [31:0] exp_dd [4];
    int          g;

    vt[0]  = '{0, 1'b1, 32'd5,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0, "wr a5"};
    vt[1]  = '{0, 1'b0, 32'd5,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0, "rd a5"};
    vt[2]  = '{1, 1'b0, 32'd0,   4'h0, 32'h0,        32'hA5A5A5A5, 1'b0, "rd a0 init"};
    vt[3]  = '{1, 1'b1, 32'd7,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0, "wr a7"};
    vt[4]  = '{0, 1'b1, 32'd7,   4'h5, 32'h11223344, 32'h0,        1'b0, "wr a7 msk5"};
    vt[5]  = '{0, 1'b0, 32'd7,   4'h0, 32'h0,        32'hDE22BE44, 1'b0, "rd a7 merged"};
    vt[6]  = '{1, 1'b0, 32'd128, 4'h0, 32'h0,        32'h0,        1'b1, "rd a128 oor"};
    vt[7]  = '{0, 1'b1, 32'd200, 4'hF, 32'h12345678, 32'h0,        1'b1, "wr a200 oor"};
    vt[8]  = '{0, 1'b0, 32'd72,  4'h0, 32'h0,        32'hA5A5A5A5, 1'b0, "rd a72 alias"};
    vt[9]  = '{1, 1'b0, 32'd200, 4'h0, 32'h0,        32'h0,        1'b1, "rd a200 oor"};
    vt[10] = '{0, 1'b1, 32'd5,   4'h0, 32'hFFFFFFFF, 32'h0,        1'b0, "wr a5 msk0"};
    vt[11] = '{1, 1'b0, 32'd5,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0, "rd a5 after msk0"};
    vt[12] = '{0, 1'b0, 32'd127, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0, "rd a127"};
    vt[13] = '{1, 1'b1, 32'd127, 4'h8, 32'hCAFEF00D, 32'h0,        1'b0, "wr a127 msk8"};
    vt[14] = '{0, 1'b0, 32'd127, 4'h0, 32'h0,        32'hCAA5A5A5, 1'b0, "rd a127 merged"};

    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.req_valid = '0; bus_a.req_we = '0; bus_a.req_addr = '0;
    bus_a.req_wmsk  = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0;
    bus_b.req_wmsk  = '0; bus_b.req_wdata = '0;

    // Reset state, and no grant while held in reset.
    repeat (3) @(negedge clk);
    bus_a.req_valid = 2'b11;
    #1 chk("a ready in reset", 64'(bus_a.req_ready), 64'd0);
    chk("a rsp_valid reset", 64'(bus_a.rsp_valid), 64'd0);
    chk("a rdata reset", 64'(bus_a.rsp_rdata), 64'd0);
    chk("a err reset", 64'(bus_a.rsp_err), 64'd0);
    chk("b rsp_valid reset", 64'(bus_b.rsp_valid), 64'd0);
    bus_a.req_valid = '0;
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    foreach (vt[i]) a_txn(vt[i]);

    // Write then read of the same word on consecutive cycles.
    @(negedge clk);
    bus_a.req_valid = 2'b01; bus_a.req_we = 2'b01;
    bus_a.req_addr[31:0] = 32'd9; bus_a.req_wmsk[3:0] = 4'hF; bus_a.req_wdata[31:0] = 32'h0BADF00D;
    #1 chk("raw wr ready", 64'(bus_a.req_ready), 64'd1);
    @(posedge clk);
    #1 bus_a.req_we = 2'b00;
    @(negedge clk);
    chk("raw wr rsp", 64'(bus_a.rsp_valid), 64'd1);
    chk("raw wr rdata", 64'(bus_a.rsp_rdata), 64'd0);
    #1 chk("raw rd ready", 64'(bus_a.req_ready), 64'd1);
    @(posedge clk);
    #1 bus_a.req_valid = '0;
    @(negedge clk);
    chk("raw rd rsp", 64'(bus_a.rsp_valid), 64'd1);
    chk("raw rd rdata", 64'(bus_a.rsp_rdata), 64'h0BADF00D);

    // Reset pulse, then both ports contend: grants alternate from port 0.
    rst_a = 1'b0;
    bus_a.req_we = '0;
    bus_a.req_addr = {32'd7, 32'd5};
    repeat (2) @(negedge clk);
    chk("a rsp_valid after rst", 64'(bus_a.rsp_valid), 64'd0);
    bus_a.req_valid = 2'b11;
    rst_a = 1'b1;
    exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_dd = '{32'hDEADBEEF, 32'hDE22BE44, 32'hDEADBEEF, 32'hDE22BE44};
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr grant", 64'(bus_a.req_ready), 64'(exp_g[k]));
      @(posedge clk);
      if (k == 3) #1 bus_a.req_valid = '0;
      @(negedge clk);
      chk("rr rsp_valid", 64'(bus_a.rsp_valid), 64'(exp_g[k]));
      chk("rr rdata", 64'(bus_a.rsp_rdata), 64'(exp_dd[k]));
    end
    @(negedge clk);
    chk("rr idle", 64'(bus_a.rsp_valid), 64'd0);

    // Randomized traffic on instance B.
    mptr = 0;
    for (int i = 0; i < int'(DEPB); i++) mmem[i] = '0;
    for (int i = 0; i < int'(NPB); i++) pend[i] = 1'b0;
    for (int i = 0; i < int'(N_EXP); i++) begin
      exp_v[i] = '0; exp_d[i] = '0; exp_e[i] = 1'b0;
    end
    for (int cyc = 0; cyc < int'(N_RAND) + 20; cyc++) begin
      @(negedge clk);
      chk("rand rsp_valid", 64'(bus_b.rsp_valid), 64'(exp_v[cyc]));
      chk("rand rdata", 64'(bus_b.rsp_rdata), 64'(exp_d[cyc]));
      chk("rand err", 64'(bus_b.rsp_err), 64'(exp_e[cyc]));
      for (int p = 0; p < int'(NPB); p++) begin
        if (!pend[p] && cyc < int'(N_RAND) && $urandom_range(0, 2) != 0) begin
          pend[p]   = 1'b1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPB + 3);
          if ($urandom_range(0, 15) == 0) p_addr[p] = $urandom;
          p_msk[p]  = 4'($urandom_range(0, 15));
          p_wd[p]   = $urandom;
        end
        bus_b.req_valid[p]         = pend[p];
        bus_b.req_we[p]            = p_we[p];
        bus_b.req_addr[p*32 +: 32] = p_addr[p];
        bus_b.req_wmsk[p*4 +: 4]   = p_msk[p];
        bus_b.req_wdata[p*32 +: 32] = p_wd[p];
      end
      g = -1;
      for (int k = 0; k < int'(NPB); k++) begin
        if (g < 0 && pend[(mptr + k) % NPB]) g = (mptr + k) % NPB;
      end
      #1 chk("rand grant", 64'(bus_b.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      if (g >= 0) begin
        exp_v[cyc+LATB] = NPB'(1 << g);
        if (p_addr[g] >= DEPB) begin
          exp_e[cyc+LATB] = 1'b1;
        end else if (!p_we[g]) begin
          exp_d[cyc+LATB] = mmem[p_addr[g]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (p_msk[g][b]) mmem[p_addr[g]][b*8 +: 8] = p_wd[g][b*8 +: 8];
        end
        mptr = (g + 1) % NPB;
        pend[g] = 1'b0;
      end
    end
    bus_b.req_valid = '0;

    // Latency RD_LAT=3 back-to-back, then again with reset right after the last accept.
    b_three(1'b0);
    b_three(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
